// File: rtl/dsp_pkg.sv
// dsp_pkg: FSM encoding and tag-word layout shared by the TDM delay scheduler.
// A line word is {real, ch, data} with data in the low bits.
package dsp_pkg;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_e;

   localparam int DATA_LSB = 0;

   function automatic int ch_lsb(input int dw);
      return DATA_LSB + dw;
   endfunction

   function automatic int tag_w(input int cw, input int dw);
      return 1 + cw + dw;
   endfunction

endpackage

// File: rtl/gated_shift_line.sv
// gated_shift_line: delay line that advances only on gate; dout is the last stage.
module gated_shift_line #(
   parameter int width = 8,
   parameter int len   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             gate,
   input  logic [width-1:0] din,
   output logic [width-1:0] dout
);

   logic [width-1:0] stage_q [len];

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int k = 0; k < len; k++) stage_q[k] <= '0;
      end else if (gate) begin
         stage_q[0] <= din;
         for (int k = 1; k < len; k++) stage_q[k] <= stage_q[k-1];
      end
   end

   assign dout = stage_q[len-1];

endmodule

// File: rtl/tdm_delay_sched.sv
// tdm_delay_sched: round-robin arbiter feeding one shared gated delay line,
// injecting bubbles once traffic stops so residual samples drain.
module tdm_delay_sched
   import dsp_pkg::*;
#(
   parameter int NCH      = 4,
   parameter int dw       = 36,
   parameter int len      = 6,
   parameter int flush_to = 16,
   parameter int CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NCH-1:0]    in_valid,
   input  logic [NCH*dw-1:0] in_data,
   output logic [NCH-1:0]    in_ready,
   input  logic              flush,
   output logic              out_valid,
   output logic [dw-1:0]     out_data,
   output logic [CW-1:0]     out_ch,
   output logic              gate,
   output logic              busy
);

   localparam int WW = tag_w(CW, dw);
   localparam int CL = ch_lsb(dw);
   localparam int OW = $clog2(len + 1);
   localparam int IW = (flush_to > 0) ? $clog2(flush_to + 1) : 1;

   state_e        state_q, state_d;
   logic [CW-1:0] rr_q, gidx;
   logic [CW-1:0] cand [NCH];
   logic [IW-1:0] idle_q, idle_d;
   logic [OW-1:0] occ_q, occ_d;
   logic          pend_q, pend_d;
   logic          accept, bubble, pop, set_pend;
   logic [WW-1:0] push_w, tail_w;
   logic          ov_q, busy_q;
   logic [dw-1:0] od_q;
   logic [CW-1:0] oc_q;

   // Scan from the highest rotated offset down so the lowest one at/after rr wins.
   always_comb begin
      in_ready = '0;
      gidx = '0;
      for (int k = NCH - 1; k >= 0; k--) begin
         cand[k] = CW'((int'(rr_q) + k) % NCH);
         if (reset && in_valid[cand[k]]) begin
            in_ready = '0;
            in_ready[cand[k]] = 1'b1;
            gidx = cand[k];
         end
      end
   end

   assign accept   = |in_ready;
   assign bubble   = reset && state_q == S_FLUSH && !accept;
   assign gate     = accept | bubble;
   assign push_w   = accept ? {1'b1, gidx, in_data[gidx*dw +: dw]} : '0;
   assign pop      = gate && tail_w[WW-1];
   assign set_pend = flush && (occ_q != '0 || accept);
   assign occ_d    = gate ? occ_q + OW'(accept) - OW'(pop) : occ_q;

   always_comb begin
      state_d = state_q;
      idle_d = accept ? '0 : idle_q;
      pend_d = pend_q | set_pend;
      if (state_q == S_IDLE) begin
         state_d = accept ? S_RUN : S_IDLE;
      end else if (state_q == S_RUN && !accept) begin
         idle_d = (idle_q == IW'(flush_to)) ? idle_q : idle_q + 1'b1;
         if (pend_q || set_pend || (flush_to != 0 && idle_d == IW'(flush_to))) state_d = S_FLUSH;
      end else if (state_q == S_FLUSH) begin
         if (accept) begin
            state_d = S_RUN;
            pend_d = flush;
         end else if (occ_d == '0) begin
            state_d = S_IDLE;
            pend_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         rr_q    <= '0;
         idle_q  <= '0;
         occ_q   <= '0;
         pend_q  <= 1'b0;
         ov_q    <= 1'b0;
         od_q    <= '0;
         oc_q    <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= accept ? ((gidx == CW'(NCH - 1)) ? '0 : gidx + 1'b1) : rr_q;
         idle_q  <= idle_d;
         occ_q   <= occ_d;
         pend_q  <= pend_d;
         ov_q    <= pop;
         od_q    <= gate ? tail_w[DATA_LSB +: dw] : od_q;
         oc_q    <= gate ? tail_w[CL +: CW] : oc_q;
         busy_q  <= state_d != S_IDLE || occ_d != '0;
      end
   end

   gated_shift_line #(.width(WW), .len(len)) u_line (
      .clk  (clk),
      .reset(reset),
      .gate (gate),
      .din  (push_w),
      .dout (tail_w)
   );

   assign out_valid = ov_q;
   assign out_data  = od_q;
   assign out_ch    = oc_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_tdm_delay_sched.sv
// tb_tdm_delay_sched: directed scenarios with hand-derived expectations, then
// randomized traffic checked against a queue-based reference model.
module tb_tdm_delay_sched;

   localparam int NCH = 4, DW = 36, LEN = 6, FT = 16, CW = 2;

   typedef struct packed {logic r; logic [CW-1:0] ch; logic [DW-1:0] d;} word_t;

   logic              clk = 1'b0, reset = 1'b0, flush = 1'b0;
   logic [NCH-1:0]    in_valid = '0, in_ready;
   logic [NCH*DW-1:0] in_data = '0;
   logic              out_valid, gate, busy;
   logic [DW-1:0]     out_data;
   logic [CW-1:0]     out_ch;

   int errors = 0, checks = 0;

   logic [NCH-1:0] obs_ready;
   logic           obs_gate, obs_ov, obs_busy;
   logic [DW-1:0]  obs_od;
   logic [CW-1:0]  obs_oc;

   int             m_mode, m_rr, m_idle, m_g;
   bit             m_pend;
   word_t          m_line[$];
   logic [NCH-1:0] exp_ready;
   logic           exp_gate, exp_ov, exp_busy;
   logic [DW-1:0]  exp_od;
   logic [CW-1:0]  exp_oc;

   always #5 clk = ~clk;

   tdm_delay_sched #(.NCH(NCH), .dw(DW), .len(LEN), .flush_to(FT)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .flush    (flush),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_ch   (out_ch),
      .gate     (gate),
      .busy     (busy)
   );

   function automatic logic [NCH*DW-1:0] pack(input logic [DW-1:0] a0, a1, a2, a3);
      return {a3, a2, a1, a0};
   endfunction

   function automatic logic [DW-1:0] rnd();
      return DW'({$urandom(), $urandom()});
   endfunction

   function automatic int occ_of();
      int n = 0;
      foreach (m_line[i]) n += int'(m_line[i].r);
      return n;
   endfunction

   // Reference model: the line is a queue of tagged words, newest at the front.
   task automatic model_comb();
      m_g = -1;
      if (reset) for (int k = 0; k < NCH; k++) begin
         int c = (m_rr + k) % NCH;
         if (m_g < 0 && ((in_valid >> c) & 1) != 0) m_g = c;
      end
      exp_ready = (m_g < 0) ? '0 : NCH'(1) << m_g;
      exp_gate = reset && (m_g >= 0 || m_mode == 2);
   endtask

   task automatic model_seq();
      bit acc;
      int occ0, occ1;
      word_t nw, old;
      if (!reset) begin
         m_mode = 0; m_rr = 0; m_idle = 0; m_pend = 0;
         m_line.delete();
         for (int i = 0; i < LEN; i++) m_line.push_back('0);
         exp_ov = 0; exp_od = '0; exp_oc = '0; exp_busy = 0;
         return;
      end
      acc = m_g >= 0;
      occ0 = occ_of();
      exp_ov = 0;
      if (exp_gate) begin
         if (acc) nw = {1'b1, CW'(m_g), DW'(in_data >> (m_g * DW))};
         else nw = '0;
         m_line.push_front(nw);
         old = m_line.pop_back();
         exp_ov = old.r; exp_od = old.d; exp_oc = old.ch;
      end
      occ1 = occ_of();
      if (flush && (occ0 > 0 || acc)) m_pend = 1;
      if (acc) begin m_rr = (m_g + 1) % NCH; m_idle = 0; end
      if (m_mode == 0) begin
         if (acc) m_mode = 1;
      end else if (m_mode == 1) begin
         if (!acc) begin
            if (m_idle < FT) m_idle++;
            if (m_pend || (FT != 0 && m_idle == FT)) m_mode = 2;
         end
      end else if (acc) begin
         m_mode = 1; m_pend = flush;
      end else if (occ1 == 0) begin
         m_mode = 0; m_pend = 0;
      end
      exp_busy = m_mode != 0 || occ1 > 0;
   endtask

   task automatic tick(input logic [NCH-1:0] v, input logic f, input logic r, input logic [NCH*DW-1:0] d);
      in_valid = v; flush = f; reset = r; in_data = d;
      model_comb();
      @(negedge clk);
      obs_ready = in_ready; obs_gate = gate;
      @(posedge clk);
      model_seq();
      #1;
      obs_ov = out_valid; obs_od = out_data; obs_oc = out_ch; obs_busy = busy;
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) tick('0, 1'b0, 1'b0, '0);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 5; i++) begin
         tick(4'b1111, 1'b0, 1'b0, pack(1, 2, 3, 4));
         checks++; if (obs_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready cyc %0d: got %b want 0000", i, obs_ready); end
         checks++; if (obs_ov !== 1'b0) begin errors++; $display("FAIL reset_out_valid cyc %0d: got %b want 0", i, obs_ov); end
         checks++; if (obs_busy !== 1'b0) begin errors++; $display("FAIL reset_busy cyc %0d: got %b want 0", i, obs_busy); end
      end
   endtask

   task automatic test_stream();
      for (int i = 1; i <= 10; i++) begin
         tick(4'b0100, 1'b0, 1'b1, pack(0, 0, DW'(i), 0));
         checks++; if (obs_ready !== 4'b0100) begin errors++; $display("FAIL stream_ready word %0d: got %b want 0100", i, obs_ready); end
         checks++; if (obs_ov !== 1'(i >= 7)) begin errors++; $display("FAIL stream_out_valid word %0d: got %b want %b", i, obs_ov, i >= 7); end
         if (i >= 7) begin
            checks++; if (obs_od !== DW'(i - 6) || obs_oc !== 2'd2) begin errors++; $display("FAIL stream_out word %0d: got ch%0d/%0d want ch2/%0d", i, obs_oc, obs_od, i - 6); end
         end
      end
      for (int j = 1; j <= FT; j++) begin
         tick('0, 1'b0, 1'b1, '0);
         checks++; if (obs_gate !== 1'b0 || obs_ov !== 1'b0 || obs_busy !== 1'b1) begin errors++; $display("FAIL stream_idle cyc %0d: gate/ov/busy got %b%b%b want 001", j, obs_gate, obs_ov, obs_busy); end
      end
      for (int b = 1; b <= 6; b++) begin
         tick('0, 1'b0, 1'b1, '0);
         checks++; if (obs_gate !== 1'b1 || obs_ov !== 1'b1) begin errors++; $display("FAIL stream_bubble %0d: gate/ov got %b%b want 11", b, obs_gate, obs_ov); end
         checks++; if (obs_od !== DW'(4 + b) || obs_oc !== 2'd2) begin errors++; $display("FAIL stream_drain %0d: got ch%0d/%0d want ch2/%0d", b, obs_oc, obs_od, 4 + b); end
         checks++; if (obs_busy !== 1'(b < 6)) begin errors++; $display("FAIL stream_busy bubble %0d: got %b want %b", b, obs_busy, b < 6); end
      end
      tick('0, 1'b0, 1'b1, '0);
      checks++; if (obs_gate !== 1'b0 || obs_busy !== 1'b0) begin errors++; $display("FAIL stream_idle_after: gate/busy got %b%b want 00", obs_gate, obs_busy); end
   endtask

   task automatic test_all_channels();
      do_reset(2);
      for (int c = 0; c < 16; c++) begin
         tick(4'b1111, 1'b0, 1'b1, pack(DW'(c*16), DW'(c*16+1), DW'(c*16+2), DW'(c*16+3)));
         checks++; if (obs_ready !== NCH'(1) << (c % 4)) begin errors++; $display("FAIL rr_grant cyc %0d: got %b want ch%0d", c, obs_ready, c % 4); end
         checks++; if (obs_ov !== 1'(c >= 6)) begin errors++; $display("FAIL rr_out_valid cyc %0d: got %b want %b", c, obs_ov, c >= 6); end
         if (c >= 6) begin
            checks++; if (obs_oc !== CW'((c - 6) % 4) || obs_od !== DW'((c - 6) * 16 + (c - 6) % 4)) begin errors++; $display("FAIL rr_out cyc %0d: got ch%0d/%0d want ch%0d/%0d", c, obs_oc, obs_od, (c - 6) % 4, (c - 6) * 16 + (c - 6) % 4); end
         end
      end
   endtask

   task automatic test_flush_pulse();
      do_reset(1);
      for (int i = 0; i < 3; i++) begin
         tick(4'b0010, 1'b0, 1'b1, pack(0, DW'(100 + i), 0, 0));
         checks++; if (obs_ready !== 4'b0010) begin errors++; $display("FAIL pulse_ready %0d: got %b want 0010", i, obs_ready); end
      end
      tick('0, 1'b1, 1'b1, '0);
      checks++; if (obs_gate !== 1'b0 || obs_busy !== 1'b1) begin errors++; $display("FAIL pulse_flush_cycle: gate/busy got %b%b want 01", obs_gate, obs_busy); end
      for (int b = 1; b <= 6; b++) begin
         tick('0, 1'b0, 1'b1, '0);
         checks++; if (obs_gate !== 1'b1 || obs_ov !== 1'(b >= 4)) begin errors++; $display("FAIL pulse_bubble %0d: gate/ov got %b%b want 1%b", b, obs_gate, obs_ov, b >= 4); end
         if (b >= 4) begin
            checks++; if (obs_od !== DW'(96 + b) || obs_oc !== 2'd1) begin errors++; $display("FAIL pulse_out %0d: got ch%0d/%0d want ch1/%0d", b, obs_oc, obs_od, 96 + b); end
         end
         checks++; if (obs_busy !== 1'(b < 6)) begin errors++; $display("FAIL pulse_busy %0d: got %b want %b", b, obs_busy, b < 6); end
      end
      tick('0, 1'b0, 1'b1, '0);
      checks++; if (obs_gate !== 1'b0 || obs_busy !== 1'b0) begin errors++; $display("FAIL pulse_idle: gate/busy got %b%b want 00", obs_gate, obs_busy); end
   endtask

   task automatic test_flush_with_valid();
      tick(4'b1000, 1'b0, 1'b1, pack(0, 0, 0, 200));
      checks++; if (obs_ready !== 4'b1000) begin errors++; $display("FAIL fv_first_ready: got %b want 1000", obs_ready); end
      tick(4'b1000, 1'b1, 1'b1, pack(0, 0, 0, 201));
      checks++; if (obs_ready !== 4'b1000 || obs_gate !== 1'b1) begin errors++; $display("FAIL fv_accept_wins: ready/gate got %b/%b want 1000/1", obs_ready, obs_gate); end
      tick('0, 1'b0, 1'b1, '0);
      checks++; if (obs_gate !== 1'b0 || obs_busy !== 1'b1) begin errors++; $display("FAIL fv_empty: gate/busy got %b%b want 01", obs_gate, obs_busy); end
      tick('0, 1'b0, 1'b1, '0);
      checks++; if (obs_gate !== 1'b1) begin errors++; $display("FAIL fv_bubble: gate got %b want 1", obs_gate); end
      tick(4'b0001, 1'b0, 1'b1, pack(202, 0, 0, 0));
      checks++; if (obs_ready !== 4'b0001 || obs_gate !== 1'b1) begin errors++; $display("FAIL fv_flush_accept: ready/gate got %b/%b want 0001/1", obs_ready, obs_gate); end
      for (int i = 0; i < 2; i++) begin
         tick('0, 1'b0, 1'b1, '0);
         checks++; if (obs_gate !== 1'b0 || obs_busy !== 1'b1) begin errors++; $display("FAIL fv_back_in_run %0d: gate/busy got %b%b want 01", i, obs_gate, obs_busy); end
      end
   endtask

   task automatic test_reset_mid_flush();
      do_reset(1);
      for (int i = 0; i < 3; i++) tick(4'b0001, 1'b0, 1'b1, pack(DW'(300 + i), 0, 0, 0));
      tick('0, 1'b1, 1'b1, '0);
      tick('0, 1'b0, 1'b0, '0);
      checks++; if (obs_gate !== 1'b0 || obs_busy !== 1'b0 || obs_ov !== 1'b0) begin errors++; $display("FAIL midreset: gate/busy/ov got %b%b%b want 000", obs_gate, obs_busy, obs_ov); end
      for (int i = 0; i < 10; i++) begin
         tick('0, 1'b0, 1'b1, '0);
         checks++; if (obs_gate !== 1'b0 || obs_ov !== 1'b0 || obs_busy !== 1'b0) begin errors++; $display("FAIL midreset_discard %0d: gate/ov/busy got %b%b%b want 000", i, obs_gate, obs_ov, obs_busy); end
      end
   endtask

   task automatic test_random();
      logic [NCH-1:0] v;
      int dens = 0;
      do_reset(1);
      for (int c = 0; c < 800; c++) begin
         if (c % 32 == 0) dens = $urandom_range(0, 3);
         v = '0;
         for (int i = 0; i < NCH; i++) if ($urandom_range(0, 3) < dens) v = v | (NCH'(1) << i);
         tick(v, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 199) != 0), pack(rnd(), rnd(), rnd(), rnd()));
         checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rand_ready cyc %0d: got %b want %b", c, obs_ready, exp_ready); end
         checks++; if (obs_gate !== exp_gate) begin errors++; $display("FAIL rand_gate cyc %0d: got %b want %b", c, obs_gate, exp_gate); end
         checks++; if (obs_ov !== exp_ov) begin errors++; $display("FAIL rand_out_valid cyc %0d: got %b want %b", c, obs_ov, exp_ov); end
         checks++; if (obs_busy !== exp_busy) begin errors++; $display("FAIL rand_busy cyc %0d: got %b want %b", c, obs_busy, exp_busy); end
         if (exp_ov) begin
            checks++; if (obs_oc !== exp_oc || obs_od !== exp_od) begin errors++; $display("FAIL rand_out cyc %0d: got ch%0d/%h want ch%0d/%h", c, obs_oc, obs_od, exp_oc, exp_od); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_all_channels();
      test_flush_pulse();
      test_flush_with_valid();
      test_reset_mid_flush();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tdm_delay_sched.md
# tdm_delay_sched

Round-robin scheduler that shares one gated delay line between NCH sample requesters in the DSP chain. Each accepted sample is tagged with its channel and shifted into the line. The line advances only on scheduler-issued gate strobes. Outputs emerge after `len` gated shifts. When traffic stops, the scheduler injects bubbles so residual samples drain instead of stalling in the line.

## Interface
- `NCH`, 4: number of requesters, ≥2.
- `dw`, 36: sample width.
- `len`, 6: delay-line depth in gated stages, ≥1.
- `flush_to`, 16: consecutive empty RUN cycles before auto-flush; 0 disables auto-flush.
- `CW`, clog2(NCH) (min 1): channel tag width, derived.
- `clk`  in  1  sole clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-low (0 = reset).
- `in_valid`  in  NCH  per-channel sample valid.
- `in_data`  in  NCH*dw  per-channel samples, channel i at bits [i*dw +: dw].
- `in_ready`  out  NCH  one-hot grant; transfer on `in_valid[i] & in_ready[i]`.
- `flush`  in  1  drain request, sampled every cycle.
- `out_valid`  out  1  one-cycle strobe, real sample on `out_data`.
- `out_data`  out  dw  delayed sample.
- `out_ch`  out  CW  channel of `out_data`.
- `gate`  out  1  delay-line advance strobe (debug/observability).
- `busy`  out  1  state≠IDLE or occupancy≠0.

## Operation
- Line word is {real, ch, data}. All stages reset to zero.
- Grant: lowest-indexed valid channel at or after pointer `rr`, wrapping. `in_ready` is combinational from `in_valid` and `rr`; at most one bit set. Nothing is granted in reset. On accept, `rr` ← granted+1 mod NCH.
- `gate` = accept | bubble. When gated, the line shifts: stage0 ← push word, stage k ← stage k−1. The prior content of stage len−1 is registered to `out_*` with `out_valid` = its real bit. Non-gated cycles: `out_valid`=0, and `out_data`/`out_ch` hold.
- Occupancy `occ` (0..len) counts real words: occ += push_real − pop_real, evaluated on gated cycles only.
- `flush_pend` sets on `flush`=1 while occ>0 or an accept is in progress. It clears on FLUSH exit.
- States:
  - IDLE: occ=0. Any valid → accept, go to RUN. `flush` is ignored.
  - RUN: valid present → accept and clear `idle_cnt`. No valid → `idle_cnt`++, no gate.
  - RUN → FLUSH on the first no-valid cycle with `flush_pend`, or when `idle_cnt` reaches `flush_to` (≠0). First bubble is pushed the following cycle.
  - FLUSH: valid present → accept instead of a bubble, return to RUN, clear `idle_cnt`. Otherwise push bubble {0,0,0}.
  - FLUSH → IDLE when occ becomes 0.
- Simultaneous valid and `flush`: the accept wins and the flush is held pending.
- Reset asserted mid-operation: all stages, occ, `rr`, `idle_cnt`, `flush_pend`, and outputs clear next edge. In-flight samples are discarded.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_ch`=0, `gate`=0, `busy`=0, `in_ready`=0, state IDLE, `rr`=0.
- Latency: a sample accepted at gated edge E shows `out_valid` at the edge of the `len`-th subsequent gated cycle. It is visible for one cycle after that edge. With back-to-back accepts this is exactly `len` clocks.
- Throughput: one accept per clock, sustained.
- `idle_cnt` width: clog2(flush_to+1). Saturates at `flush_to`.
- `busy` is registered and reflects state/occ after the current edge.

## Structure
- Shared package `dsp_pkg`: state encoding (IDLE/RUN/FLUSH) and the tag-word field layout constants.
- Sub-module `gated_shift_line` (params width, len; ports clk, reset, gate, din, dout). It holds the stages and the registered tail tap.
- Top holds the arbiter, FSM, occupancy, idle counter, and flush_pend.

## Test plan
- Hold `reset`=0 for 5 cycles with `in_valid`=4'b1111 → `in_ready`=0, `out_valid`=0, `busy`=0 throughout.
- Ch2 streams words 1..10 back-to-back (len=6) → words 1–4 out during accepts of 7–10 with `out_ch`=2. After 16 empty cycles, FLUSH begins and words 5–10 emerge on bubbles 1–6. IDLE follows, then `busy`=0.
- All four channels valid continuously → grants 0,1,2,3,0,… one per cycle. `out_valid` is continuous starting 6 cycles after the first accept, with the same `out_ch` order.
- Accept 3 words, drop valid, pulse `flush` one cycle → FLUSH next cycle. Words out on bubbles 4, 5, 6, then IDLE.
- `flush`=1 together with a valid → accept that cycle, flush pending. FLUSH starts on the first empty cycle. A new valid during FLUSH is accepted with no bubble and the block returns to RUN.
- Assert `reset` during FLUSH with occ=3 → next edge occ=0 and `busy`=0. No `out_valid` for the discarded words after reset release.
